// File: rtl/debug_step_controller.sv
// -----------------------------------------------------------------------------
// debug_step_controller
//
// Single-step debug sequencer. Turns host debug commands (HALT, RUN, STEP N,
// RUN_TO_BP) into a registered per-cycle clock-enable for the gated system
// clock and counts every design cycle it releases.
//
// Ports
//   sys_clk_ext   free-running clock, all logic on its rising edge
//   reset_n       asynchronous active-low reset
//   debug_enable  level, 0 = free-run (clock never gated)
//   cmd_valid     one-cycle command strobe
//   cmd_op        00 HALT, 01 RUN, 10 STEP, 11 RUN_TO_BP
//   cmd_arg       step count for STEP
//   bp_cycle      breakpoint cycle value, sampled when RUN_TO_BP is accepted
//   ext_break     level, external break request
//   count_clear   one-cycle strobe, zeroes cycle_count (wins over increment)
//   clk_en        registered; each high cycle releases one design clock
//   cycle_count   number of clk_en-high cycles, wraps modulo 2^CNT_WIDTH
//   halted        high in HALT
//   cmd_ack       one-cycle pulse, command accepted
//   cmd_err       one-cycle pulse, command rejected and ignored
//   state         00 DISABLED, 01 HALT, 10 RUN, 11 STEP
// -----------------------------------------------------------------------------
module debug_step_controller #(
    parameter int CNT_WIDTH  = 32,
    parameter int STEP_WIDTH = 16
) (
    input  logic                  sys_clk_ext,
    input  logic                  reset_n,
    input  logic                  debug_enable,
    input  logic                  cmd_valid,
    input  logic [1:0]            cmd_op,
    input  logic [STEP_WIDTH-1:0] cmd_arg,
    input  logic [CNT_WIDTH-1:0]  bp_cycle,
    input  logic                  ext_break,
    input  logic                  count_clear,
    output logic                  clk_en,
    output logic [CNT_WIDTH-1:0]  cycle_count,
    output logic                  halted,
    output logic                  cmd_ack,
    output logic                  cmd_err,
    output logic [1:0]            state
);

    typedef enum logic [1:0] {
        ST_DISABLED = 2'b00,
        ST_HALT     = 2'b01,
        ST_RUN      = 2'b10,
        ST_STEP     = 2'b11
    } state_t;

    localparam logic [1:0] OP_HALT      = 2'b00;
    localparam logic [1:0] OP_RUN       = 2'b01;
    localparam logic [1:0] OP_STEP      = 2'b10;
    localparam logic [1:0] OP_RUN_TO_BP = 2'b11;

    state_t                state_q;
    logic [STEP_WIDTH-1:0] step_rem;
    logic [CNT_WIDTH-1:0]  bp_latch;
    logic                  bp_armed;

    logic [CNT_WIDTH-1:0]  count_next;
    logic                  halt_cmd;
    logic                  bp_hit;
    logic                  step_last;

    // Counter value after this edge. The breakpoint is compared against this
    // post-increment value, so the run stops with cycle_count equal to the
    // breakpoint exactly; modular equality makes the compare wrap-safe.
    always_comb begin
        count_next = cycle_count;
        if (count_clear)
            count_next = '0;
        else if (clk_en)
            count_next = cycle_count + CNT_WIDTH'(1);
    end

    assign halt_cmd  = cmd_valid && (cmd_op == OP_HALT);
    assign bp_hit    = bp_armed && (count_next == bp_latch);
    // In STEP the remainder is always >= 1; reaching 1 means this edge ends
    // the last requested pulse.
    assign step_last = (step_rem == STEP_WIDTH'(1));
    assign state     = state_q;

    always_ff @(posedge sys_clk_ext or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_HALT;
            clk_en      <= 1'b0;
            cycle_count <= '0;
            halted      <= 1'b1;
            cmd_ack     <= 1'b0;
            cmd_err     <= 1'b0;
            step_rem    <= '0;
            bp_latch    <= '0;
            bp_armed    <= 1'b0;
        end else begin
            cycle_count <= count_next;
            cmd_ack     <= 1'b0;
            cmd_err     <= 1'b0;

            if (!debug_enable) begin
                // Free-run overrides everything, including pending commands.
                state_q  <= ST_DISABLED;
                clk_en   <= 1'b1;
                halted   <= 1'b0;
                step_rem <= '0;
                bp_armed <= 1'b0;
                cmd_err  <= cmd_valid;
            end else begin
                unique case (state_q)
                    ST_DISABLED: begin
                        state_q <= ST_HALT;
                        clk_en  <= 1'b0;
                        halted  <= 1'b1;
                        cmd_err <= cmd_valid;
                    end

                    ST_HALT: begin
                        clk_en <= 1'b0;
                        halted <= 1'b1;
                        if (cmd_valid) begin
                            case (cmd_op)
                                OP_HALT: begin
                                    cmd_ack <= 1'b1;
                                end
                                OP_RUN: begin
                                    if (ext_break) begin
                                        cmd_err <= 1'b1;
                                    end else begin
                                        cmd_ack  <= 1'b1;
                                        state_q  <= ST_RUN;
                                        clk_en   <= 1'b1;
                                        halted   <= 1'b0;
                                        bp_armed <= 1'b0;
                                    end
                                end
                                OP_STEP: begin
                                    if (ext_break) begin
                                        cmd_err <= 1'b1;
                                    end else begin
                                        cmd_ack <= 1'b1;
                                        // STEP 0 is a harmless no-op.
                                        if (cmd_arg != '0) begin
                                            state_q  <= ST_STEP;
                                            step_rem <= cmd_arg;
                                            clk_en   <= 1'b1;
                                            halted   <= 1'b0;
                                        end
                                    end
                                end
                                OP_RUN_TO_BP: begin
                                    // A breakpoint equal to the current count
                                    // could only be hit after a full wrap.
                                    if (ext_break || (bp_cycle == cycle_count)) begin
                                        cmd_err <= 1'b1;
                                    end else begin
                                        cmd_ack  <= 1'b1;
                                        bp_latch <= bp_cycle;
                                        bp_armed <= 1'b1;
                                        state_q  <= ST_RUN;
                                        clk_en   <= 1'b1;
                                        halted   <= 1'b0;
                                    end
                                end
                            endcase
                        end
                    end

                    ST_RUN: begin
                        cmd_ack <= halt_cmd;
                        cmd_err <= cmd_valid && !halt_cmd;
                        if (ext_break || halt_cmd || bp_hit) begin
                            state_q  <= ST_HALT;
                            clk_en   <= 1'b0;
                            halted   <= 1'b1;
                            bp_armed <= 1'b0;
                        end
                    end

                    ST_STEP: begin
                        cmd_ack  <= halt_cmd;
                        cmd_err  <= cmd_valid && !halt_cmd;
                        step_rem <= step_rem - STEP_WIDTH'(1);
                        if (ext_break || halt_cmd || step_last) begin
                            state_q  <= ST_HALT;
                            clk_en   <= 1'b0;
                            halted   <= 1'b1;
                            step_rem <= '0;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_debug_step_controller.sv
// -----------------------------------------------------------------------------
// Bench for debug_step_controller. A counter width of 10 bits is used so the
// wrap-around case can be reached by free-running a short time.
// -----------------------------------------------------------------------------
module tb_debug_step_controller;

    localparam int CW = 10;
    localparam int SW = 16;

    localparam logic [1:0] OP_HALT = 2'b00;
    localparam logic [1:0] OP_RUN  = 2'b01;
    localparam logic [1:0] OP_STEP = 2'b10;
    localparam logic [1:0] OP_RTB  = 2'b11;

    localparam int M_DIS  = 0;
    localparam int M_HALT = 1;
    localparam int M_RUN  = 2;
    localparam int M_STEP = 3;

    logic          clk;
    logic          reset_n;
    logic          de;
    logic          cmd_valid;
    logic [1:0]    cmd_op;
    logic [SW-1:0] cmd_arg;
    logic [CW-1:0] bp_cycle;
    logic          eb;
    logic          count_clear;
    logic          clk_en;
    logic [CW-1:0] cycle_count;
    logic          halted;
    logic          cmd_ack;
    logic          cmd_err;
    logic [1:0]    state;

    int checks   = 0;
    int failures = 0;

    // Behavioural model
    int            m_mode   = M_HALT;
    int            m_target = 0;
    int            m_issued = 0;
    logic [CW-1:0] m_count  = '0;
    logic [CW-1:0] m_bp     = '0;
    bit            m_armed  = 1'b0;
    bit            m_clk_en = 1'b0;
    bit            m_ack    = 1'b0;
    bit            m_err    = 1'b0;

    debug_step_controller #(.CNT_WIDTH(CW), .STEP_WIDTH(SW)) dut (
        .sys_clk_ext (clk),
        .reset_n     (reset_n),
        .debug_enable(de),
        .cmd_valid   (cmd_valid),
        .cmd_op      (cmd_op),
        .cmd_arg     (cmd_arg),
        .bp_cycle    (bp_cycle),
        .ext_break   (eb),
        .count_clear (count_clear),
        .clk_en      (clk_en),
        .cycle_count (cycle_count),
        .halted      (halted),
        .cmd_ack     (cmd_ack),
        .cmd_err     (cmd_err),
        .state       (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode   = M_HALT;
        m_target = 0;
        m_issued = 0;
        m_count  = '0;
        m_bp     = '0;
        m_armed  = 1'b0;
        m_clk_en = 1'b0;
        m_ack    = 1'b0;
        m_err    = 1'b0;
    endtask

    // One clock edge of the specified behaviour, applied to the inputs that
    // were stable across that edge.
    task automatic model_step();
        logic [CW-1:0] nc;
        bit            stop;
        m_ack = 1'b0;
        m_err = 1'b0;
        nc = count_clear ? '0 : (m_clk_en ? m_count + CW'(1) : m_count);
        if (m_clk_en && m_mode == M_STEP) m_issued++;
        if (!de) begin
            m_mode = M_DIS;
            m_err  = cmd_valid;
        end else if (m_mode == M_DIS) begin
            m_mode = M_HALT;
            m_err  = cmd_valid;
        end else if (m_mode == M_HALT) begin
            if (cmd_valid) begin
                if (cmd_op == OP_HALT) m_ack = 1'b1;
                else if (eb) m_err = 1'b1;
                else if (cmd_op == OP_RUN) begin
                    m_ack = 1'b1; m_mode = M_RUN; m_armed = 1'b0;
                end else if (cmd_op == OP_STEP) begin
                    m_ack = 1'b1;
                    if (cmd_arg != '0) begin
                        m_mode = M_STEP; m_target = int'(cmd_arg); m_issued = 0;
                    end
                end else if (bp_cycle == m_count) m_err = 1'b1;
                else begin
                    m_ack = 1'b1; m_mode = M_RUN; m_armed = 1'b1; m_bp = bp_cycle;
                end
            end
        end else begin
            if (cmd_valid) begin
                m_ack = (cmd_op == OP_HALT);
                m_err = !m_ack;
            end
            stop = eb || (cmd_valid && cmd_op == OP_HALT);
            if (m_mode == M_RUN && m_armed && nc == m_bp) stop = 1'b1;
            if (m_mode == M_STEP && m_issued >= m_target) stop = 1'b1;
            if (stop) m_mode = M_HALT;
        end
        m_count  = nc;
        m_clk_en = (m_mode != M_HALT);
    endtask

    // Compare process: advance the model and check every output each cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) model_reset();
            else model_step();
            check("clk_en",      64'(clk_en),      64'(m_clk_en));
            check("cycle_count", 64'(cycle_count), 64'(m_count));
            check("halted",      64'(halted),      64'(m_mode == M_HALT));
            check("state",       64'(state),       64'(m_mode));
            check("cmd_ack",     64'(cmd_ack),     64'(m_ack));
            check("cmd_err",     64'(cmd_err),     64'(m_err));
        end
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [SW-1:0] arg, input logic [CW-1:0] bp);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        bp_cycle  = bp;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic count_pulses(input int window, output int pulses);
        pulses = 0;
        repeat (window) begin
            if (clk_en) pulses++;
            tick();
        end
    endtask

    task automatic clear_count();
        count_clear = 1'b1;
        tick();
        count_clear = 1'b0;
    endtask

    int pulses;

    initial begin
        reset_n = 1'b0; de = 1'b1; cmd_valid = 1'b0; cmd_op = OP_HALT;
        cmd_arg = '0; bp_cycle = '0; eb = 1'b0; count_clear = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        tick();
        check("rst_state",  64'(state),       64'(1));
        check("rst_halted", 64'(halted),      64'(1));
        check("rst_clk_en", 64'(clk_en),      64'(0));
        check("rst_count",  64'(cycle_count), 64'(0));

        // STEP 5
        send_cmd(OP_STEP, 16'd5, '0);
        check("step5_ack", 64'(cmd_ack), 64'(1));
        count_pulses(12, pulses);
        check("step5_pulses", 64'(pulses), 64'(5));
        check("step5_count",  64'(cycle_count), 64'(5));
        check("step5_halted", 64'(halted), 64'(1));

        // RUN_TO_BP 100 from 0, then again from 100
        clear_count();
        send_cmd(OP_RTB, '0, CW'(100));
        count_pulses(130, pulses);
        check("bp100_pulses", 64'(pulses), 64'(100));
        check("bp100_count",  64'(cycle_count), 64'(100));
        send_cmd(OP_RTB, '0, CW'(100));
        check("bp_eq_err", 64'(cmd_err), 64'(1));
        count_pulses(5, pulses);
        check("bp_eq_pulses", 64'(pulses), 64'(0));

        // RUN, STEP rejected mid-run, HALT after 20 pulses
        clear_count();
        send_cmd(OP_RUN, '0, '0);
        for (int i = 1; i <= 20; i++) begin
            if (i == 5)  begin cmd_valid = 1'b1; cmd_op = OP_STEP; cmd_arg = 16'd3; end
            if (i == 20) begin cmd_valid = 1'b1; cmd_op = OP_HALT; end
            tick();
            cmd_valid = 1'b0;
            if (i == 5) begin
                check("run_step_err",   64'(cmd_err), 64'(1));
                check("run_continues",  64'(clk_en),  64'(1));
            end
        end
        check("halt_clk_en", 64'(clk_en), 64'(0));
        check("halt_count",  64'(cycle_count), 64'(20));
        check("halt_ack",    64'(cmd_ack), 64'(1));

        // STEP 1000 aborted by ext_break during pulse 37
        clear_count();
        send_cmd(OP_STEP, 16'd1000, '0);
        repeat (36) tick();
        eb = 1'b1;
        tick();
        check("brk_clk_en", 64'(clk_en), 64'(0));
        check("brk_count",  64'(cycle_count), 64'(37));
        check("brk_halted", 64'(halted), 64'(1));
        send_cmd(OP_RUN, '0, '0);
        check("brk_run_err", 64'(cmd_err), 64'(1));
        check("brk_run_clk", 64'(clk_en), 64'(0));
        eb = 1'b0;

        // Wrap: free-run to 2^CW-3, then RUN_TO_BP 2
        de = 1'b0;
        tick();
        for (int i = 0; i < 1100; i++) begin
            if (m_count == CW'(1020)) break;
            tick();
        end
        de = 1'b1;
        tick();
        check("preload_count", 64'(cycle_count), 64'(1021));
        send_cmd(OP_RTB, '0, CW'(2));
        count_pulses(10, pulses);
        check("wrap_pulses", 64'(pulses), 64'(5));
        check("wrap_count",  64'(cycle_count), 64'(2));

        // count_clear coincident with clk_en
        send_cmd(OP_RUN, '0, '0);
        repeat (3) tick();
        clear_count();
        check("clr_count", 64'(cycle_count), 64'(0));
        send_cmd(OP_HALT, '0, '0);

        // debug_enable dropped mid-STEP, then re-enabled
        send_cmd(OP_STEP, 16'd50, '0);
        repeat (4) tick();
        de = 1'b0;
        tick();
        check("dis_state",  64'(state),  64'(0));
        check("dis_clk_en", 64'(clk_en), 64'(1));
        repeat (3) tick();
        de = 1'b1;
        tick();
        check("reen_state",  64'(state),  64'(1));
        check("reen_clk_en", 64'(clk_en), 64'(0));

        // Asynchronous reset mid-RUN
        send_cmd(OP_RUN, '0, '0);
        repeat (5) tick();
        reset_n = 1'b0;
        #1;
        check("arst_clk_en", 64'(clk_en),      64'(0));
        check("arst_count",  64'(cycle_count), 64'(0));
        check("arst_halted", 64'(halted),      64'(1));
        tick();
        reset_n = 1'b1;
        tick();

        // Randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            de          = ($urandom_range(0, 99) < 96);
            eb          = ($urandom_range(0, 99) < 3);
            count_clear = ($urandom_range(0, 99) < 2);
            cmd_valid   = ($urandom_range(0, 99) < 15);
            cmd_op      = 2'($urandom_range(0, 3));
            cmd_arg     = SW'($urandom_range(0, 12));
            bp_cycle    = ($urandom_range(0, 3) == 0) ? CW'($urandom)
                                                      : m_count + CW'($urandom_range(0, 40));
            tick();
        end
        cmd_valid = 1'b0; eb = 1'b0; count_clear = 1'b0; de = 1'b1;
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
